oam_dma: RTL and testbench
==========================

// Module: oam_dma
// PURPOSE
//  Primary sprite OAM (256x8) plus its CPU access path: OAMADDR ($2003), OAMDATA ($2004) and
//  the $4014 OAM DMA engine. Sits directly upstream of the sprite engine, supplying its OAMDATA
//  from the address the sprite engine drives while rendering. Stalls the CPU during DMA and
//  streams 256 bytes from page $XX00 into OAM on alternating get/put CPU cycles.
// PARAMETERS
//  OAM_DEPTH  256  OAM bytes; fixed, the address is 8 bits
//  ATTR_MASK  8'hE3  mask applied to byte 2 of every sprite (addr[1:0]==2) on write
// PORTS
//  clock         in   1   system clock
//  reset         in   1   synchronous, active-high reset
//  cpu_ce        in   1   one-clock CPU-cycle enable; all state below advances only when cpu_ce=1
//  oamaddr_we    in   1   CPU write to $2003
//  oamdata_we    in   1   CPU write to $2004
//  oamdata_re    in   1   CPU read of $2004 (no side effects)
//  dma_we        in   1   CPU write to $4014
//  cpu_wdata     in   8   CPU write data
//  cpu_rdata     out  8   $2004 read data (combinational)
//  rendering     in   1   1 = sprite engine owns the OAM read port
//  se_oamaddr    in   8   sprite-engine OAM read address
//  se_oamdata    out  8   OAM byte at se_oamaddr (combinational)
//  dma_rd        out  1   DMA bus read strobe (GET cycle)
//  dma_addr      out  16  DMA bus address {page, count}
//  dma_rdata     in   8   bus data; valid in the same cycle as dma_rd
//  cpu_stall     out  1   CPU halt request
// BEHAVIOUR
//  Reset: oamaddr=0, state=IDLE, parity=0, count=0, latch=0; cpu_stall=0, dma_rd=0, dma_addr=0.
//   OAM contents are not cleared; a reset during DMA aborts it and drops cpu_stall next clock.
//  Parity bit toggles on every cpu_ce; 0 = even (GET-eligible) cycle.
//  Write to $2003: oamaddr <= cpu_wdata.
//  Write to $2004: if rendering=0, mem[oamaddr] <= cpu_wdata (masked when oamaddr[1:0]==2) and
//   oamaddr <= oamaddr+1, wrapping 8'hFF->8'h00. If rendering=1: ignored, oamaddr unchanged.
//  Read of $2004: cpu_rdata = mem[rendering ? se_oamaddr : oamaddr]; oamaddr does not change.
//  se_oamdata = mem[se_oamaddr] at all times, so the read path adds zero cycles.
//  State machine (transitions only on cpu_ce):
//   IDLE : a $4014 write latches page=cpu_wdata and sets count=0 -> HALT.
//   HALT : cpu_stall=1; no bus access. -> GET if the HALT cycle is odd, otherwise -> ALIGN.
//   ALIGN: cpu_stall=1; no bus access. -> GET.
//   GET  : cpu_stall=1, dma_rd=1, dma_addr={page,count}; latch <= dma_rdata. -> PUT.
//   PUT  : cpu_stall=1; mem[oamaddr+count] <= latch (masked per rule above); count <= count+1.
//          -> IDLE if count==255, else -> GET.
//  Stall length is 513 cycles when HALT is odd and 514 when HALT is even.
//  DMA writes start at the current oamaddr and wrap modulo 256; oamaddr is the same before and after.
//  DMA writes ignore rendering. dma_addr holds its last value when not in GET.
//  Ignored while state!=IDLE: further $4014 writes, and $2003/$2004 accesses.
//  $2003 and $2004 writes in the same cycle: the $2003 write wins and no OAM write occurs.
//  A $4014 write in the same cycle as a $2004 write: both take effect.
// TESTING
//  1 $2003<=8'hFE; $2004<=11,22,33 -> mem[FE]=11, mem[FF]=22, mem[00]=33, oamaddr=8'h01.
//  2 $2003<=8'h02; $2004<=8'hFF -> mem[02]=8'hE3; $2004 read with rendering=0 returns mem[03].
//  3 $4014<=8'h02 with HALT odd, bus returns addr[7:0]^8'h5A -> stall exactly 513 cycles,
//    dma_addr $0200..$02FF in order, mem[i]=i^5A (masked at i%4==2).
//  4 Same as 3 with HALT even -> stall exactly 514 cycles; first dma_rd one cycle later.
//  5 oamaddr=8'h10, then DMA -> byte k lands at (k+16)%256, oamaddr=8'h10 at end.
//  6 rendering=1: $2004 write is ignored and se_oamdata tracks se_oamaddr every clock;
//    reset at GET #100 -> cpu_stall=0 next clock and mem[0..98] retained.

Source files
------------

// File: rtl/oam_dma.sv
// Primary sprite OAM (256x8) with the CPU OAMADDR/OAMDATA access path and the $4014 DMA engine
// that stalls the CPU and streams one 256-byte page into OAM on alternating get/put cycles.
module oam_dma #(
  parameter int          OAM_DEPTH = 256,
  parameter logic [7:0]  ATTR_MASK = 8'hE3
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_cpu_ce,
  input  logic        i_oamaddr_we,
  input  logic        i_oamdata_we,
  input  logic        i_oamdata_re,
  input  logic        i_dma_we,
  input  logic [7:0]  i_cpu_wdata,
  output logic [7:0]  o_cpu_rdata,
  input  logic        i_rendering,
  input  logic [7:0]  i_se_oamaddr,
  output logic [7:0]  o_se_oamdata,
  output logic        o_dma_rd,
  output logic [15:0] o_dma_addr,
  input  logic [7:0]  i_dma_rdata,
  output logic        o_cpu_stall
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_GET   = 3'd3,
    S_PUT   = 3'd4
  } state_t;

  state_t      r_state;
  logic [7:0]  r_oamaddr;
  logic        r_parity;
  logic [7:0]  r_count;
  logic [7:0]  r_latch;
  logic [7:0]  r_page;
  logic        r_stall;
  logic        r_dma_rd;
  logic [15:0] r_dma_addr;
  logic [7:0]  r_mem [OAM_DEPTH];

  logic        w_mem_we;
  logic [7:0]  w_mem_addr;
  logic [7:0]  w_mem_wdata;
  logic [7:0]  w_cpu_rd_addr;
  logic        w_unused_oamdata_re;

  // Reads of $2004 have no side effects, so the strobe carries no information here.
  assign w_unused_oamdata_re = i_oamdata_re;

  // Sprite byte 2 holds attributes whose bits 4:2 do not exist in hardware.
  function automatic logic [7:0] f_mask(input logic [7:0] addr, input logic [7:0] data);
    return (addr[1:0] == 2'd2) ? (data & ATTR_MASK) : data;
  endfunction

  // NOTE: every variable gets a default first so the decode cannot infer a latch.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = r_oamaddr;
    w_mem_wdata = i_cpu_wdata;
    if (!i_reset && i_cpu_ce) begin
      if (r_state == S_PUT) begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_oamaddr + r_count;
        w_mem_wdata = r_latch;
      end else if (r_state == S_IDLE && i_oamdata_we && !i_oamaddr_we && !i_rendering) begin
        w_mem_we = 1'b1;
      end
    end
  end

  // NOTE: OAM contents are deliberately not reset; a plain write port maps onto RAM.
  always_ff @(posedge i_clock) begin
    if (w_mem_we) r_mem[w_mem_addr] <= f_mask(w_mem_addr, w_mem_wdata);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_oamaddr  <= 8'h00;
      r_parity   <= 1'b0;
      r_count    <= 8'h00;
      r_latch    <= 8'h00;
      r_page     <= 8'h00;
      r_stall    <= 1'b0;
      r_dma_rd   <= 1'b0;
      r_dma_addr <= 16'h0000;
    end else if (i_cpu_ce) begin
      r_parity <= ~r_parity;
      case (r_state)
        S_IDLE: begin
          if (i_oamaddr_we)
            r_oamaddr <= i_cpu_wdata;
          else if (i_oamdata_we && !i_rendering)
            r_oamaddr <= r_oamaddr + 8'd1;
          if (i_dma_we) begin
            r_page  <= i_cpu_wdata;
            r_count <= 8'h00;
            r_stall <= 1'b1;
            r_state <= S_HALT;
          end
        end
        // An odd halt cycle means the next cycle is already GET-eligible.
        S_HALT: begin
          if (r_parity) begin
            r_state    <= S_GET;
            r_dma_rd   <= 1'b1;
            r_dma_addr <= {r_page, r_count};
          end else begin
            r_state <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          r_state    <= S_GET;
          r_dma_rd   <= 1'b1;
          r_dma_addr <= {r_page, r_count};
        end
        S_GET: begin
          r_latch  <= i_dma_rdata;
          r_dma_rd <= 1'b0;
          r_state  <= S_PUT;
        end
        S_PUT: begin
          r_count <= r_count + 8'd1;
          if (r_count == 8'hFF) begin
            r_stall <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_dma_rd   <= 1'b1;
            r_dma_addr <= {r_page, r_count + 8'd1};
            r_state    <= S_GET;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_cpu_rd_addr = i_rendering ? i_se_oamaddr : r_oamaddr;
  assign o_cpu_rdata   = r_mem[w_cpu_rd_addr];
  assign o_se_oamdata  = r_mem[i_se_oamaddr];
  assign o_dma_rd      = r_dma_rd;
  assign o_dma_addr    = r_dma_addr;
  assign o_cpu_stall   = r_stall;

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: stimulus pushes expected reads, DMA addresses and stall shapes;
// a negedge monitor pops and compares whenever the DUT presents the corresponding output.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset, cpu_ce, oamaddr_we, oamdata_we, oamdata_re, dma_we, rendering;
  logic [7:0]  cpu_wdata, se_oamaddr, cpu_rdata, se_oamdata, dma_rdata, bus_xor;
  logic        dma_rd, cpu_stall;
  logic [15:0] dma_addr;

  always #5 clk = ~clk;

  oam_dma dut (
    .i_clock(clk), .i_reset(reset), .i_cpu_ce(cpu_ce),
    .i_oamaddr_we(oamaddr_we), .i_oamdata_we(oamdata_we), .i_oamdata_re(oamdata_re),
    .i_dma_we(dma_we), .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(cpu_rdata),
    .i_rendering(rendering), .i_se_oamaddr(se_oamaddr), .o_se_oamdata(se_oamdata),
    .o_dma_rd(dma_rd), .o_dma_addr(dma_addr), .i_dma_rdata(dma_rdata), .o_cpu_stall(cpu_stall)
  );

  // Bus model: page byte at offset a reads back as a ^ bus_xor.
  assign dma_rdata = dma_addr[7:0] ^ bus_xor;

  typedef struct { string name; int kind; logic [15:0] val; } exp_t;
  typedef struct { int len; int first; } stall_t;

  exp_t        q_rd[$];
  logic [15:0] q_dma[$];
  stall_t      q_stall[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        rd_req = 1'b0;
  logic        tb_parity = 1'b0;
  logic [7:0]  m_mem [256];
  logic [7:0]  m_oamaddr;

  exp_t        mon_e;
  stall_t      mon_s;
  logic [15:0] mon_act;
  int          stall_cnt = 0;
  int          first_at = 0;

  function automatic logic [7:0] mask(input logic [7:0] a, input logic [7:0] d);
    return (a % 4 == 2) ? (d & 8'hE3) : d;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: expected event missing or unexpected", name);
  endtask

  always @(posedge clk) begin
    if (reset) tb_parity <= 1'b0;
    else if (cpu_ce) tb_parity <= ~tb_parity;
  end

  // Monitor: compares whatever the DUT presents in this cycle against the queues.
  always @(negedge clk) begin
    if (rd_req) begin
      if (q_rd.size() == 0) fail("rd_queue_empty");
      else begin
        mon_e = q_rd.pop_front();
        case (mon_e.kind)
          0:       mon_act = {8'h00, cpu_rdata};
          1:       mon_act = {8'h00, se_oamdata};
          2:       mon_act = {15'h0, cpu_stall};
          3:       mon_act = {15'h0, dma_rd};
          default: mon_act = dma_addr;
        endcase
        check(mon_e.name, {16'h0, mon_act}, {16'h0, mon_e.val});
      end
    end
    if (cpu_stall) stall_cnt++;
    else if (stall_cnt != 0) begin
      if (q_stall.size() == 0) fail("stall_unexpected");
      else begin
        mon_s = q_stall.pop_front();
        check("stall_len", stall_cnt, mon_s.len);
        check("first_get_pos", first_at, mon_s.first);
      end
      stall_cnt = 0;
      first_at  = 0;
    end
    if (dma_rd) begin
      if (first_at == 0) first_at = stall_cnt;
      if (q_dma.size() == 0) fail("dma_rd_extra");
      else check("dma_addr", {16'h0, dma_addr}, {16'h0, q_dma.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr2003(input logic [7:0] d);
    oamaddr_we = 1'b1; cpu_wdata = d; tick(); oamaddr_we = 1'b0;
    m_oamaddr = d;
  endtask

  task automatic wr2004(input logic [7:0] d);
    oamdata_we = 1'b1; cpu_wdata = d; tick(); oamdata_we = 1'b0;
    if (!rendering) begin
      m_mem[m_oamaddr] = mask(m_oamaddr, d);
      m_oamaddr++;
    end
  endtask

  task automatic expect_out(input string name, input int kind, input logic [15:0] v);
    exp_t e;
    e.name = name; e.kind = kind; e.val = v;
    q_rd.push_back(e);
    rd_req = 1'b1; tick(); rd_req = 1'b0;
  endtask

  task automatic rd2004(input string name);
    oamdata_re = 1'b1;
    expect_out(name, 0, {8'h00, m_mem[rendering ? se_oamaddr : m_oamaddr]});
    oamdata_re = 1'b0;
  endtask

  task automatic rd_se(input string name, input logic [7:0] a);
    se_oamaddr = a;
    expect_out(name, 1, {8'h00, m_mem[a]});
  endtask

  task automatic rd_all(input string tag);
    for (int i = 0; i < 256; i++) rd_se($sformatf("%s_mem%0d", tag, i), 8'(i));
  endtask

  // abort_at = n > 0 asserts reset during the n-th GET cycle.
  task automatic run_dma(input logic [7:0] page, input logic [7:0] xr, input bit halt_odd,
                         input int abort_at, input bit disturb);
    stall_t s;
    int base, n, got, budget;
    logic [7:0] a;
    bus_xor = xr;
    while (tb_parity != (halt_odd ? 1'b0 : 1'b1)) tick();
    base = halt_odd ? 1 : 2;
    n = (abort_at == 0) ? 256 : abort_at;
    for (int i = 0; i < n; i++) q_dma.push_back({page, 8'(i)});
    s.len   = (abort_at == 0) ? base + 512 : base + 2 * abort_at - 1;
    s.first = base + 1;
    q_stall.push_back(s);
    for (int k = 0; k < ((abort_at == 0) ? 256 : abort_at - 1); k++) begin
      a = m_oamaddr + 8'(k);
      m_mem[a] = mask(a, 8'(k) ^ xr);
    end
    dma_we = 1'b1; cpu_wdata = page; tick(); dma_we = 1'b0;
    if (disturb) begin
      repeat (10) tick();
      oamaddr_we = 1'b1; dma_we = 1'b1; cpu_wdata = 8'h80; tick();
      oamaddr_we = 1'b0; dma_we = 1'b0;
      oamdata_we = 1'b1; cpu_wdata = 8'h66; tick(); oamdata_we = 1'b0;
    end
    got = 0;
    budget = 0;
    if (abort_at != 0) begin
      while (1) begin
        if (dma_rd) begin
          got++;
          if (got == abort_at) begin
            reset = 1'b1; tick(); reset = 1'b0;
            m_oamaddr = 8'h00;
            break;
          end
        end
        if (++budget > 2000) begin fail("abort_get_timeout"); break; end
        tick();
      end
    end else begin
      while (cpu_stall && budget < 2000) begin budget++; tick(); end
      if (budget >= 2000) fail("dma_end_timeout");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cpu_ce = 1'b1; oamaddr_we = 1'b0; oamdata_we = 1'b0; oamdata_re = 1'b0;
    dma_we = 1'b0; rendering = 1'b0; cpu_wdata = 8'h00; se_oamaddr = 8'h00; bus_xor = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    m_oamaddr = 8'h00;
    expect_out("rst_stall", 2, 16'h0);
    expect_out("rst_dma_rd", 3, 16'h0);
    expect_out("rst_dma_addr", 4, 16'h0);

    // Wrap of oamaddr across FF->00; a write without cpu_ce must be dropped.
    wr2003(8'h01); wr2004(8'h77);
    wr2003(8'hFE); wr2004(8'h11); wr2004(8'h22); wr2004(8'h33);
    cpu_ce = 1'b0; oamdata_we = 1'b1; cpu_wdata = 8'hEE; tick(); oamdata_we = 1'b0; cpu_ce = 1'b1;
    rd2004("t1_oamaddr_01");
    rd_se("t1_memFE", 8'hFE); rd_se("t1_memFF", 8'hFF); rd_se("t1_mem00", 8'h00);

    // Attribute masking, then read-back at the incremented address.
    wr2003(8'h03); wr2004(8'h3C);
    wr2003(8'h02); wr2004(8'hFF);
    rd2004("t2_rd_mem03");
    rd_se("t2_mask_mem02", 8'h02);

    // $2003 and $2004 together: address load wins, no OAM write.
    wr2003(8'h40); wr2004(8'h12); wr2004(8'h34);
    oamaddr_we = 1'b1; oamdata_we = 1'b1; cpu_wdata = 8'h41; tick();
    oamaddr_we = 1'b0; oamdata_we = 1'b0;
    m_oamaddr = 8'h41;
    rd2004("same_cycle_mem41");

    // Rendering blocks $2004 writes and steers the CPU read port.
    rendering = 1'b1;
    wr2004(8'h99);
    se_oamaddr = 8'hFE;
    rd2004("render_rd_seFE");
    rendering = 1'b0;
    rd2004("render_wr_ignored");

    wr2003(8'h00);
    run_dma(8'h02, 8'h5A, 1'b1, 0, 1'b0);
    rd_all("t3");

    run_dma(8'h03, 8'hC3, 1'b0, 0, 1'b1);
    rd2004("t4_oamaddr_kept");
    rd_all("t4");

    wr2003(8'h10);
    run_dma(8'h05, 8'h5A, 1'b1, 0, 1'b0);
    rd2004("t5_oamaddr_10");
    rd_all("t5");

    rendering = 1'b1;
    wr2004(8'h99);
    rd_se("t6_ignored_mem10", 8'h10);
    for (int i = 0; i < 8; i++) rd_se($sformatf("t6_track%0d", i), 8'(i * 37 + 3));
    wr2003(8'h00);
    run_dma(8'h07, 8'hA5, 1'b1, 100, 1'b0);
    expect_out("t6_abort_stall", 2, 16'h0);
    expect_out("t6_abort_dma_rd", 3, 16'h0);
    expect_out("t6_abort_dma_addr", 4, 16'h0);
    for (int i = 0; i < 100; i++) rd_se($sformatf("t6_mem%0d", i), 8'(i));
    rendering = 1'b0;

    repeat (4) tick();
    if (q_rd.size() != 0)    fail("rd_left_unchecked");
    if (q_dma.size() != 0)   fail("dma_rd_missing");
    if (q_stall.size() != 0) fail("stall_missing");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
